// File: rtl/new_usb_pkg.sv
// Shared types for the USB host nonperiodic scheduler: list selector and FSM states.
package new_usb_pkg;

  typedef enum logic {
    NP_CONTROL = 1'b0,
    NP_BULK    = 1'b1
  } new_usb_np_list_e;

  typedef enum logic [2:0] {
    NP_IDLE      = 3'd0,
    NP_PICK      = 3'd1,
    NP_ISSUE     = 3'd2,
    NP_WAIT_DONE = 3'd3,
    NP_EMPTY     = 3'd4
  } new_usb_np_state_e;

endpackage

// File: rtl/new_usb_nonperiodic_listselect.sv
// Chooses control or bulk list per ED inside the nonperiodic window, enforcing the
// CBSR ratio through the external counter's overflow/threshold flags.
module new_usb_nonperiodic_listselect
  import new_usb_pkg::*;
#(
  parameter int WaitDoneTimeout = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       nonperiodic_window_i,
  input  logic       cle_i,
  input  logic       ble_i,
  input  logic       clf_i,
  input  logic       blf_i,
  input  logic       control_ed_null_i,
  input  logic       bulk_ed_null_i,
  input  logic       counter_overflown_i,
  input  logic       counter_is_threshold_i,
  output logic       req_valid_o,
  input  logic       req_ready_i,
  output logic       req_list_o,
  output logic       req_last_control_o,
  input  logic       ed_done_i,
  input  logic       ed_td_served_i,
  output logic       served_control_td_o,
  output logic       served_bulk_td_o,
  output logic       reload_control_head_o,
  output logic       reload_bulk_head_o,
  output logic       clear_clf_o,
  output logic       clear_blf_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  localparam int CntW = (WaitDoneTimeout > 1) ? $clog2(WaitDoneTimeout) : 1;

  new_usb_np_state_e state_q, state_d;
  new_usb_np_list_e  list_q, list_d;
  logic              last_q, last_d;
  logic              served_c_q, served_b_q;
  logic [CntW-1:0]   to_cnt_q;
  logic              to_hit;
  logic              ctrl_ok, bulk_ok, ctrl_end, bulk_end;

  assign ctrl_ok  = cle_i & ~control_ed_null_i;
  assign bulk_ok  = ble_i & ~bulk_ed_null_i;
  assign ctrl_end = cle_i & control_ed_null_i & clf_i;
  assign bulk_end = ble_i & bulk_ed_null_i & blf_i;

  assign to_hit = (WaitDoneTimeout != 0) && (state_q == NP_WAIT_DONE) && !ed_done_i &&
                  (to_cnt_q == CntW'(WaitDoneTimeout - 1));

  // Request handshake: req_valid_o rises the cycle after PICK and stays high, with
  // req_list_o/req_last_control_o frozen, until the cycle where req_ready_i is also high.
  always_comb begin
    state_d               = state_q;
    list_d                = list_q;
    last_d                = last_q;
    reload_control_head_o = 1'b0;
    reload_bulk_head_o    = 1'b0;
    clear_clf_o           = 1'b0;
    clear_blf_o           = 1'b0;
    case (state_q)
      NP_IDLE: if (nonperiodic_window_i) state_d = NP_PICK;
      NP_PICK: begin
        if (!nonperiodic_window_i) begin
          state_d = NP_IDLE;
        end else if (ctrl_end) begin
          reload_control_head_o = 1'b1;
          clear_clf_o           = 1'b1;
        end else if (bulk_end) begin
          reload_bulk_head_o = 1'b1;
          clear_blf_o        = 1'b1;
        end else if (counter_overflown_i && bulk_ok) begin
          list_d  = NP_BULK;
          last_d  = 1'b0;
          state_d = NP_ISSUE;
        end else if (ctrl_ok) begin
          list_d  = NP_CONTROL;
          last_d  = counter_is_threshold_i;
          state_d = NP_ISSUE;
        end else if (bulk_ok) begin
          list_d  = NP_BULK;
          last_d  = 1'b0;
          state_d = NP_ISSUE;
        end else begin
          state_d = NP_EMPTY;
        end
      end
      NP_ISSUE: if (req_ready_i) state_d = NP_WAIT_DONE;
      NP_WAIT_DONE: begin
        if (ed_done_i) state_d = nonperiodic_window_i ? NP_PICK : NP_IDLE;
        else if (to_hit) state_d = NP_IDLE;
      end
      NP_EMPTY: begin
        if (!nonperiodic_window_i) state_d = NP_IDLE;
        else if ((cle_i && clf_i) || (ble_i && blf_i)) state_d = NP_PICK;
      end
      default: state_d = NP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= NP_IDLE;
      list_q     <= NP_CONTROL;
      last_q     <= 1'b0;
      served_c_q <= 1'b0;
      served_b_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      last_q     <= last_d;
      served_c_q <= (state_q == NP_WAIT_DONE) && ed_done_i && ed_td_served_i &&
                    (list_q == NP_CONTROL);
      served_b_q <= (state_q == NP_WAIT_DONE) && ed_done_i && ed_td_served_i &&
                    (list_q == NP_BULK);
      if (WaitDoneTimeout != 0 && state_q == NP_WAIT_DONE && state_d == NP_WAIT_DONE)
        to_cnt_q <= to_cnt_q + CntW'(1);
      else
        to_cnt_q <= '0;
    end
  end

  assign req_valid_o         = (state_q == NP_ISSUE);
  assign req_list_o          = list_q;
  assign req_last_control_o  = last_q;
  assign served_control_td_o = served_c_q;
  assign served_bulk_td_o    = served_b_q;
  assign timeout_o           = to_hit;
  assign state_o             = state_q;

endmodule

// File: tb/tb_new_usb_nonperiodic_listselect.sv
// Cycle-by-cycle vector table for the nonperiodic list selector, plus timeout and
// asynchronous-reset sequences.
module tb_new_usb_nonperiodic_listselect;

  // Input vector bit positions
  localparam logic [11:0] WIN = 12'h800, CLE = 12'h400, BLE = 12'h200, CLF = 12'h100;
  localparam logic [11:0] BLF = 12'h080, CN  = 12'h040, BN  = 12'h020, OVF = 12'h010;
  localparam logic [11:0] THR = 12'h008, RDY = 12'h004, DONE = 12'h002, SRV = 12'h001;
  localparam logic [11:0] B   = WIN | CLE | BLE;
  // Output vector bit positions
  localparam logic [9:0] VALID = 10'h200, LIST = 10'h100, LAST = 10'h080, SC = 10'h040;
  localparam logic [9:0] SB = 10'h020, RC = 10'h010, RB = 10'h008, CCLF = 10'h004;
  localparam logic [9:0] CBLF = 10'h002, TO = 10'h001, NONE = 10'h000;
  localparam logic [2:0] S_IDLE = 3'd0, S_PICK = 3'd1, S_ISSUE = 3'd2, S_WAIT = 3'd3;
  localparam logic [2:0] S_EMPTY = 3'd4;

  typedef struct {
    logic [11:0] in;
    logic [2:0]  st;
    logic [9:0]  out;
  } vec_t;

  logic clk, rst;
  logic win, cle, ble, clf, blf, cnull, bnull, ovf, thr, rdy, done, srv;
  logic req_valid, req_list, req_last, served_c, served_b;
  logic reload_c, reload_b, clr_clf, clr_blf, tmo;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  new_usb_nonperiodic_listselect #(.WaitDoneTimeout(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .nonperiodic_window_i(win), .cle_i(cle), .ble_i(ble), .clf_i(clf), .blf_i(blf),
    .control_ed_null_i(cnull), .bulk_ed_null_i(bnull),
    .counter_overflown_i(ovf), .counter_is_threshold_i(thr),
    .req_valid_o(req_valid), .req_ready_i(rdy), .req_list_o(req_list),
    .req_last_control_o(req_last), .ed_done_i(done), .ed_td_served_i(srv),
    .served_control_td_o(served_c), .served_bulk_td_o(served_b),
    .reload_control_head_o(reload_c), .reload_bulk_head_o(reload_b),
    .clear_clf_o(clr_clf), .clear_blf_o(clr_blf), .timeout_o(tmo), .state_o(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [11:0] in, logic [2:0] st, logic [9:0] out);
    vec_t v;
    v.in = in; v.st = st; v.out = out;
    return v;
  endfunction

  function automatic logic [12:0] act_bits();
    return {state, req_valid, req_list, req_last, served_c, served_b,
            reload_c, reload_b, clr_clf, clr_blf, tmo};
  endfunction

  // Driver
  task automatic set_inputs(input logic [11:0] v);
    {win, cle, ble, clf, blf, cnull, bnull, ovf, thr, rdy, done, srv} = v;
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic got, seen;

    vecs.push_back(mk(B,                  S_IDLE,  NONE));
    vecs.push_back(mk(B,                  S_PICK,  NONE));
    vecs.push_back(mk(B | RDY,            S_ISSUE, VALID));
    vecs.push_back(mk(B | DONE | SRV,     S_WAIT,  NONE));
    vecs.push_back(mk(B | OVF,            S_PICK,  SC));
    vecs.push_back(mk(B | RDY,            S_ISSUE, VALID | LIST));
    vecs.push_back(mk(B,                  S_WAIT,  LIST));
    vecs.push_back(mk(B | DONE | SRV,     S_WAIT,  LIST));
    vecs.push_back(mk(B | THR,            S_PICK,  SB | LIST));
    vecs.push_back(mk(B,                  S_ISSUE, VALID | LAST));
    vecs.push_back(mk(B | RDY,            S_ISSUE, VALID | LAST));
    vecs.push_back(mk(B | DONE,           S_WAIT,  LAST));
    vecs.push_back(mk(B | CN | CLF,       S_PICK,  RC | CCLF | LAST));
    vecs.push_back(mk(B,                  S_PICK,  LAST));
    vecs.push_back(mk(B | RDY,            S_ISSUE, VALID));
    vecs.push_back(mk(CLE | BLE | DONE | SRV, S_WAIT, NONE));
    vecs.push_back(mk(CLE | BLE,          S_IDLE,  SC));
    vecs.push_back(mk(B | CN | BN,        S_IDLE,  NONE));
    vecs.push_back(mk(B | CN | BN,        S_PICK,  NONE));
    vecs.push_back(mk(B | CN | BN,        S_EMPTY, NONE));
    vecs.push_back(mk(B | CN | BN,        S_EMPTY, NONE));
    vecs.push_back(mk(B | CN | BN | BLF,  S_EMPTY, NONE));
    vecs.push_back(mk(B | CN | BN | BLF,  S_PICK,  RB | CBLF));
    vecs.push_back(mk(B | CN,             S_PICK,  NONE));
    vecs.push_back(mk(B | CN | RDY,       S_ISSUE, VALID | LIST));
    vecs.push_back(mk(B | CN | DONE,      S_WAIT,  LIST));
    vecs.push_back(mk(B | CN | BN | CLF | BLF, S_PICK, RC | CCLF | LIST));
    vecs.push_back(mk(B | BN | BLF,       S_PICK,  RB | CBLF | LIST));
    vecs.push_back(mk(B,                  S_PICK,  LIST));
    vecs.push_back(mk(B,                  S_ISSUE, VALID));
    vecs.push_back(mk(B,                  S_ISSUE, VALID));
    vecs.push_back(mk(CLE | BLE,          S_ISSUE, VALID));
    vecs.push_back(mk(CLE | BLE,          S_ISSUE, VALID));
    vecs.push_back(mk(CLE | BLE,          S_ISSUE, VALID));
    vecs.push_back(mk(CLE | BLE | RDY,    S_ISSUE, VALID));
    vecs.push_back(mk(CLE | BLE | DONE | SRV, S_WAIT, NONE));
    vecs.push_back(mk(CLE | BLE,          S_IDLE,  SC));
    vecs.push_back(mk(CLE | BLE,          S_IDLE,  NONE));
    vecs.push_back(mk(CLE | BLE,          S_IDLE,  NONE));

    rst = 1'b1;
    set_inputs(B);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(act_bits()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      set_inputs(vecs[i].in);
      @(negedge clk);
      check($sformatf("vec%0d", i + 1), 32'(act_bits()), 32'({vecs[i].st, vecs[i].out}));
      @(posedge clk);
      #1;
    end

    // WAIT_DONE timeout: request, accept, never complete
    set_inputs(B);
    n = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      n++;
      if (req_valid) got = 1'b1;
    end
    check("to_req_latency", 32'(n), 32'd3);
    check("to_req_list", 32'(req_list), 32'd0);
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    n = 0; got = 1'b0; seen = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      n++;
      if (served_c || served_b) seen = 1'b1;
      if (tmo) got = 1'b1;
    end
    check("to_latency", 32'(n), 32'd8);
    @(negedge clk);
    if (served_c || served_b) seen = 1'b1;
    check("to_no_served", 32'(seen), 32'd0);
    check("to_state_idle", 32'(state), 32'(S_IDLE));
    check("to_pulse_width", 32'(tmo), 32'd0);

    // Asynchronous reset while a request is pending
    n = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      n++;
      if (req_valid) got = 1'b1;
    end
    check("rst_req_seen", 32'(got), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'(act_bits()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
